// File: rtl/cic_pkg.sv
// Shared definitions for the decimating CIC filter.
//  cic_acc_w   : accumulator width needed for bit-growth-free wrap arithmetic
//  ORDER_MAX   : largest supported number of integrator/comb stages
//  rate_log2_t : rate_log2 field type for the default RMAX_LOG2 of 6
package cic_pkg;

  localparam int unsigned ORDER_MAX      = 6;
  localparam int unsigned RMAX_LOG2_DFLT = 6;

  typedef logic [$clog2(RMAX_LOG2_DFLT+1)-1:0] rate_log2_t;

  // Register growth of the CIC is ORDER*log2(R), so this width makes the
  // modulo-2^ACC_W integrator wrap cancel exactly in the comb section.
  function automatic int unsigned cic_acc_w(input int unsigned width,
                                            input int unsigned order,
                                            input int unsigned rmax_log2);
    return width + order * rmax_log2;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section (differential delay 1) of the CIC decimator.
//  clk, reset (async, active-high), clear (sync flush)
//  en : decimated-rate enable; y <= x - x_prev, x_prev <= x
//  x  : input from previous stage, y : registered difference output
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int unsigned ACC_W = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] x,
  output logic signed [ACC_W-1:0] y
);

  logic signed [ACC_W-1:0] x_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y      <= '0;
      x_prev <= '0;
    end else if (clear) begin
      y      <= '0;
      x_prev <= '0;
    end else if (en) begin
      y      <= x - x_prev;
      x_prev <= x;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// N-stage decimating CIC filter, runtime decimation R = 2**rate_log2,
// gain normalised by an arithmetic right shift of ORDER*rate_log2.
//  clk, reset (async, active-high), clear (sync flush, reloads rate)
//  rate_log2 : sampled only at reset/clear
//  in_valid / in_data   : input samples, accepted on any cycle
//  out_valid / out_data : one-cycle strobe, signed result with FRAC fractional bits
// Build option: define CIC_ROUND_EN to round half up before the
// normalising shift; otherwise the shift truncates toward -inf.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int unsigned ORDER     = 3,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned RMAX_LOG2 = 6,
  parameter int unsigned FRAC      = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic [$clog2(RMAX_LOG2+1)-1:0]   rate_log2,
  input  logic                             in_valid,
  input  logic signed [WIDTH-1:0]          in_data,
  output logic                             out_valid,
  output logic signed [WIDTH+FRAC-1:0]     out_data
);

  localparam int unsigned ACC_W = cic_acc_w(WIDTH, ORDER, RMAX_LOG2);
  localparam int unsigned RW    = $clog2(RMAX_LOG2+1);
  localparam int unsigned PH_W  = (RMAX_LOG2 > 0) ? RMAX_LOG2 : 1;
  // One guard bit above ACC_W+FRAC absorbs the rounding increment.
  localparam int unsigned EXT_W = ACC_W + FRAC + 1;

  logic [RW-1:0]           rate_q;
  logic [PH_W-1:0]         phase;
  logic [PH_W-1:0]         phase_last;
  logic                    dec_stb;
  logic signed [ACC_W-1:0] integ [ORDER];
  logic signed [ACC_W-1:0] comb_y [ORDER];
  logic [ORDER-1:0]        comb_vld;

  // R-1 as a mask of rate_q low ones.
  always_comb begin
    phase_last = ~({PH_W{1'b1}} << rate_q);
  end

  // Integrator chain, phase counter, decimation strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_q  <= rate_log2;
      phase   <= '0;
      dec_stb <= 1'b0;
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (clear) begin
      rate_q  <= rate_log2;
      phase   <= '0;
      dec_stb <= 1'b0;
      for (int unsigned k = 0; k < ORDER; k++) integ[k] <= '0;
    end else begin
      dec_stb <= 1'b0;
      if (in_valid) begin
        integ[0] <= integ[0] + ACC_W'(in_data);
        for (int unsigned k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        if (phase == phase_last) begin
          phase   <= '0;
          dec_stb <= 1'b1;
        end else begin
          phase <= phase + PH_W'(1);
        end
      end
    end
  end

  // Valid bit travels one comb stage per clock alongside the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comb_vld <= '0;
    end else if (clear) begin
      comb_vld <= '0;
    end else begin
      comb_vld[0] <= dec_stb;
      for (int unsigned k = 1; k < ORDER; k++) comb_vld[k] <= comb_vld[k-1];
    end
  end

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    if (k == 0) begin : g_first
      cic_comb_stage #(.ACC_W(ACC_W)) u_comb (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (dec_stb),
        .x     (integ[ORDER-1]),
        .y     (comb_y[0])
      );
    end else begin : g_next
      cic_comb_stage #(.ACC_W(ACC_W)) u_comb (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .en    (comb_vld[k-1]),
        .x     (comb_y[k-1]),
        .y     (comb_y[k])
      );
    end
  end

  // (x <<< FRAC) >>> (ORDER*rate_q) folded into one net shift so the
  // rounding constant lines up with the bits actually discarded.
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] scaled;
  logic signed [31:0]      sh_net;

  always_comb begin
    ext     = EXT_W'(comb_y[ORDER-1]);
    sh_net  = (ORDER * 32'(rate_q)) - 32'(FRAC);
    rounded = ext;
    scaled  = ext;
    if (sh_net > 0) begin
`ifdef CIC_ROUND_EN
      rounded = ext + (EXT_W'(1) <<< (sh_net - 1));
`else
      rounded = ext;
`endif
      scaled = rounded >>> sh_net;
    end else begin
      scaled = ext <<< (-sh_net);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= comb_vld[ORDER-1];
      if (comb_vld[ORDER-1]) out_data <= (WIDTH+FRAC)'(scaled);
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Self-checking bench for cic_decimator: default instance (FRAC=0) plus a
// FRAC=2 instance sharing the same stimulus.
module tb_cic_decimator;
  import cic_pkg::*;

  logic              clk;
  logic              reset;
  logic              clear;
  rate_log2_t        rate_log2;
  logic              in_valid;
  logic signed [11:0] in_data;
  logic              out_valid;
  logic signed [11:0] out_data;
  logic              out_valid2;
  logic signed [13:0] out_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q1[$];
  int q1c[$];
  int q2[$];

  cic_decimator #(.ORDER(3), .WIDTH(12), .RMAX_LOG2(6), .FRAC(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .rate_log2(rate_log2),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  cic_decimator #(.ORDER(3), .WIDTH(12), .RMAX_LOG2(6), .FRAC(2)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .rate_log2(rate_log2),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_data(out_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      q1.push_back(int'(out_data));
      q1c.push_back(cyc);
    end
    if (out_valid2) q2.push_back(int'(out_data2));
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input int d);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = v;
    in_data  = 12'(d);
  endtask

  task automatic do_reset(input rate_log2_t r);
    @(negedge clk);
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    rate_log2 = r;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int qget(input int which, input int idx);
    if (which == 1) return (idx < q1.size()) ? q1[idx] : -999999;
    if (which == 2) return (idx < q2.size()) ? q2[idx] : -999999;
    return (idx < q1c.size()) ? q1c[idx] : -999999;
  endfunction

  typedef struct {
    rate_log2_t rate;
    int         dc;
    int         n_out;
    int         skip;
    int         exp1;
    int         exp2;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   s1, s2, s3, acc, iter, last_c;
    int   exp_c[$];
    int   exp_imp[4];

    // rate, dc, outputs, settling outputs skipped, expected FRAC=0, FRAC=2
    vecs[0] = '{rate: 3'd2, dc:   100, n_out: 6, skip: 2, exp1:   100, exp2:   400};
    vecs[1] = '{rate: 3'd6, dc: -2048, n_out: 5, skip: 2, exp1: -2048, exp2: -8192};
    vecs[2] = '{rate: 3'd6, dc:  2047, n_out: 5, skip: 2, exp1:  2047, exp2:  8188};
    vecs[3] = '{rate: 3'd0, dc:    -7, n_out: 4, skip: 2, exp1:    -7, exp2:   -28};
    vecs[4] = '{rate: 3'd3, dc:  1234, n_out: 5, skip: 2, exp1:  1234, exp2:  4936};
    vecs[5] = '{rate: 3'd2, dc:     5, n_out: 5, skip: 2, exp1:     5, exp2:    20};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; rate_log2 = 3'd2;

    // Reset state
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_data2", int'(out_data2), 0);
    @(negedge clk);
    reset = 1'b0;

    // DC vectors
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].rate);
      s1 = q1.size();
      s2 = q2.size();
      for (int i = 0; i < (vecs[v].n_out << vecs[v].rate); i++) tick(1'b1, vecs[v].dc);
      for (int i = 0; i < 8; i++) tick(1'b0, 0);
      check($sformatf("vec%0d_count", v), q1.size() - s1, vecs[v].n_out);
      for (int j = vecs[v].skip; j < vecs[v].n_out; j++) begin
        check($sformatf("vec%0d_out%0d", v, j), qget(1, s1 + j), vecs[v].exp1);
        check($sformatf("vec%0d_frac_out%0d", v, j), qget(2, s2 + j), vecs[v].exp2);
      end
    end

    // Async reset mid-stream on the FRAC=2 instance (last vector: DC 5, R=4)
    check("hold_out_data2", int'(out_data2), 20);
    for (int i = 0; i < 3; i++) tick(1'b1, 5);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_data2", int'(out_data2), 0);
    check("async_out_valid2", int'(out_valid2), 0);
    check("async_out_data", int'(out_data), 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;

    // Impulse response at R=2: full-precision 0,12,4,0 divided by 8
`ifdef CIC_ROUND_EN
    exp_imp[0] = 0; exp_imp[1] = 2; exp_imp[2] = 1; exp_imp[3] = 0;
`else
    exp_imp[0] = 0; exp_imp[1] = 1; exp_imp[2] = 0; exp_imp[3] = 0;
`endif
    do_reset(3'd1);
    s1 = q1.size();
    tick(1'b1, 4);
    for (int i = 0; i < 7; i++) tick(1'b1, 0);
    for (int i = 0; i < 8; i++) tick(1'b0, 0);
    check("impulse_count", q1.size() - s1, 4);
    for (int j = 0; j < 4; j++) check($sformatf("impulse_out%0d", j), qget(1, s1 + j), exp_imp[j]);

    // Random 1/3 duty input at R=8: count and 5-cycle latency
    do_reset(3'd3);
    s3 = q1c.size();
    acc = 0;
    iter = 0;
    while (acc < 80 && iter < 2000) begin
      @(negedge clk);
      clear = 1'b0;
      in_valid = ($urandom_range(2) == 0);
      in_data = 12'($urandom_range(4095));
      if (in_valid) begin
        acc++;
        if (acc % 8 == 0) exp_c.push_back(cyc);
      end
      iter++;
    end
    tick(1'b0, 0);
    for (int i = 0; i < 8; i++) tick(1'b0, 0);
    check("gap_accepted", acc, 80);
    check("gap_count", q1c.size() - s3, 10);
    for (int j = 0; j < exp_c.size(); j++)
      check($sformatf("gap_latency%0d", j), qget(3, s3 + j) - exp_c[j], 5);

    // Mid-frame clear with rate change 2->4 and coincident in_valid
    do_reset(3'd2);
    for (int i = 0; i < 6; i++) tick(1'b1, 10);
    @(negedge clk);
    clear = 1'b1;
    rate_log2 = 3'd4;
    in_valid = 1'b1;
    in_data = 12'd10;
    s1 = q1.size();
    last_c = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 10);
      last_c = cyc;
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 0);
    check("clear_count", q1.size() - s1, 1);
    check("clear_latency", qget(3, s1) - last_c, 5);
    check("clear_out", qget(1, s1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
